// File: rtl/facq_prn_capture.sv
// rtl/facq_prn_capture.sv - serial chip stream decimator and 32-bit word packer into block RAM
// Optional feature macro: FACQ_PRN_CAPTURE_SYNC_EN (ARM waits for the sync epoch strobe).
module facq_prn_capture #(
    parameter int RAM_SIZE  = 4096,
    localparam int DEPTH     = (RAM_SIZE - 1) / 32 + 1,
    localparam int ADDR_BITS = $clog2(RAM_SIZE),
    localparam int WORD_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sync,
    input  logic [ADDR_BITS-1:0] cfg_length,
    input  logic                 cfg_reverse,
    input  logic [2:0]           freq_div,
    input  logic                 din,
    input  logic                 din_valid,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] wr_cntr,
    input  logic                 rd_en,
    input  logic [WORD_BITS-1:0] rd_addr,
    output logic [31:0]          rd_data,
    output logic                 rd_valid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_BITS-1:0] LAST_BIT  = ADDR_BITS'(RAM_SIZE - 1);
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(DEPTH - 1);

    logic [2:0]           r_state;
    logic [ADDR_BITS-1:0] r_len;
    logic                 r_reverse;
    logic [2:0]           r_div_m1;
    logic [2:0]           r_rep;
    logic [4:0]           r_bit_cntr;
    logic [ADDR_BITS-1:0] r_total;
    logic [31:0]          r_word;
    logic                 r_wr_pend;
    logic [WORD_BITS-1:0] r_wr_cntr;
    logic                 r_done;
    logic [31:0]          r_ram [DEPTH];
    logic [31:0]          r_rd_data;
    logic                 r_rd_valid;

    logic                 w_arm_go;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_busy;
    logic [4:0]           w_pos;
    logic [31:0]          w_word_next;
    logic                 w_ram_we;

`ifdef FACQ_PRN_CAPTURE_SYNC_EN
    assign w_arm_go = sync;
`else
    logic w_unused_sync;
    assign w_unused_sync = sync;
    assign w_arm_go      = 1'b1;
`endif

    assign w_busy   = (r_state == S_ARM) || (r_state == S_CAPTURE) || (r_state == S_FLUSH);
    assign w_accept = (r_state == S_CAPTURE) && din_valid && (r_rep == r_div_m1);
    assign w_last   = (r_total == r_len);
    assign w_pos    = r_reverse ? ~r_bit_cntr : r_bit_cntr;
    assign w_ram_we = r_wr_pend || (r_state == S_FLUSH);

    // A word that was just handed to the RAM starts the next word from zero.
    always_comb begin
        w_word_next        = r_wr_pend ? 32'd0 : r_word;
        w_word_next[w_pos] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_reverse  <= 1'b0;
            r_div_m1   <= 3'd0;
            r_rep      <= 3'd0;
            r_bit_cntr <= 5'd0;
            r_total    <= '0;
            r_word     <= 32'd0;
            r_wr_pend  <= 1'b0;
            r_wr_cntr  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_wr_pend <= 1'b0;
            if (r_wr_pend) begin
                r_word    <= 32'd0;
                r_wr_cntr <= r_wr_cntr + WORD_BITS'(1);
            end

            if (abort && w_busy) begin
                r_state <= S_IDLE;
            end else if (abort && (r_state == S_DONE)) begin
                r_done <= 1'b0;
            end else if (abort) begin
                r_done <= r_done;
            end else if (start) begin
                r_len      <= (cfg_length > LAST_BIT) ? LAST_BIT : cfg_length;
                r_reverse  <= cfg_reverse;
                r_div_m1   <= (freq_div == 3'd0) ? 3'd0 : freq_div - 3'd1;
                r_rep      <= 3'd0;
                r_bit_cntr <= 5'd0;
                r_total    <= '0;
                r_word     <= 32'd0;
                r_wr_pend  <= 1'b0;
                r_wr_cntr  <= '0;
                r_done     <= 1'b0;
                r_state    <= S_ARM;
            end else begin
                case (r_state)
                    S_ARM: begin
                        if (w_arm_go) begin
                            r_rep   <= 3'd0;
                            r_state <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (din_valid) begin
                            r_rep <= (r_rep == r_div_m1) ? 3'd0 : r_rep + 3'd1;
                        end
                        if (w_accept) begin
                            r_word     <= w_word_next;
                            r_bit_cntr <= r_bit_cntr + 5'd1;
                            r_total    <= r_total + ADDR_BITS'(1);
                            // A word completed by the final bit is left for FLUSH to write.
                            if (w_last) begin
                                r_state <= S_FLUSH;
                            end else if (r_bit_cntr == 5'd31) begin
                                r_wr_pend <= 1'b1;
                            end
                        end
                    end
                    S_FLUSH: begin
                        r_word    <= 32'd0;
                        r_wr_cntr <= (r_wr_cntr == LAST_WORD) ? r_wr_cntr : r_wr_cntr + WORD_BITS'(1);
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_wr_cntr] <= r_word;
        end
    end

    // Reads see the RAM before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_ram[rd_addr];
            end
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign wr_cntr  = r_wr_cntr;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_facq_prn_capture.sv
// tb/tb_facq_prn_capture.sv - self-checking bench for facq_prn_capture
module tb_facq_prn_capture;

    localparam int RAM_SIZE  = 4096;
    localparam int ADDR_BITS = 12;
    localparam int WORD_BITS = 7;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 sync;
    logic [ADDR_BITS-1:0] cfg_length;
    logic                 cfg_reverse;
    logic [2:0]           freq_div;
    logic                 din;
    logic                 din_valid;
    logic                 busy;
    logic                 done;
    logic [WORD_BITS-1:0] wr_cntr;
    logic                 rd_en;
    logic [WORD_BITS-1:0] rd_addr;
    logic [31:0]          rd_data;
    logic                 rd_valid;

    facq_prn_capture #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sync(sync),
        .cfg_length(cfg_length), .cfg_reverse(cfg_reverse), .freq_div(freq_div),
        .din(din), .din_valid(din_valid), .busy(busy), .done(done), .wr_cntr(wr_cntr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        q_din [$];
    logic        q_val [$];
    logic [31:0] exp_words [$];
    logic [31:0] got_words [$];
    int          last_idx;

    typedef struct {
        int          len;
        bit          rev;
        int          div;
        int          kind;
        bit          first;
        int          nchk;
        logic [31:0] w0;
        logic [31:0] w1;
        int          wr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected words from the rules: the k-th valid sample (0-based) is a chip's last when (k+1) % div == 0.
    task automatic model(input int len, input bit rev, input int div);
        int eff_div, nb, acc, vcnt, pos;
        logic [31:0] w;
        eff_div  = (div == 0) ? 1 : div;
        nb       = ((len > RAM_SIZE - 1) ? RAM_SIZE - 1 : len) + 1;
        acc      = 0;
        vcnt     = 0;
        last_idx = -1;
        exp_words = {};
        for (int i = 0; i < (nb + 31) / 32; i++) exp_words.push_back(32'd0);
        for (int i = 0; i < q_din.size(); i++) begin
            if (q_val[i]) begin
                vcnt++;
                if ((vcnt % eff_div == 0) && (acc < nb)) begin
                    pos = rev ? 31 - (acc % 32) : acc % 32;
                    w = exp_words[acc / 32];
                    w[pos] = q_din[i];
                    exp_words[acc / 32] = w;
                    acc++;
                    if (acc == nb) last_idx = i;
                end
            end
        end
    endtask

    task automatic gen_pattern(input int n, input int kind, input bit first);
        q_din = {};
        q_val = {};
        for (int k = 0; k < n; k++) begin
            q_din.push_back(kind == 1 ? 1'b1 : ((k % 2 == 0) ? first : ~first));
            q_val.push_back(1'b1);
        end
    endtask

    task automatic gen_random(input int len, input int div);
        int eff_div, nb, acc, vcnt;
        logic v;
        eff_div = (div == 0) ? 1 : div;
        nb      = len + 1;
        acc     = 0;
        vcnt    = 0;
        q_din   = {};
        q_val   = {};
        while (acc < nb) begin
            v = ($urandom_range(0, 3) != 0);
            q_din.push_back(1'($urandom));
            q_val.push_back(v);
            if (v) begin
                vcnt++;
                if (vcnt % eff_div == 0) acc++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            q_din.push_back(1'($urandom));
            q_val.push_back(1'b1);
        end
    endtask

    task automatic read_pair(input int a0, input int a1, output logic [31:0] d0, output logic [31:0] d1);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a0[WORD_BITS-1:0];
        @(negedge clk);
        d0 = rd_data;
        check("rd_valid first", 32'(rd_valid), 32'd1);
        rd_addr = a1[WORD_BITS-1:0];
        @(negedge clk);
        d1 = rd_data;
        check("rd_valid back-to-back", 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
        @(negedge clk);
        check("rd_valid pulse end", 32'(rd_valid), 32'd0);
    endtask

    task automatic run_capture(input int len, input bit rev, input int div, input string tag);
        int nw;
        logic [31:0] d0, d1;
        model(len, rev, div);
        nw = exp_words.size();
        @(negedge clk);
        start       = 1'b1;
        cfg_length  = ADDR_BITS'(len);
        cfg_reverse = rev;
        freq_div    = 3'(div);
        din_valid   = 1'b1;
        din         = 1'($urandom);
        @(negedge clk);
        start       = 1'b0;
        sync        = 1'b1;
        cfg_length  = ADDR_BITS'($urandom);
        cfg_reverse = ~rev;
        freq_div    = 3'($urandom);
        din         = 1'($urandom);
        for (int i = 0; i < q_din.size(); i++) begin
            @(negedge clk);
            sync      = 1'b0;
            din       = q_din[i];
            din_valid = q_val[i];
            if (i == last_idx + 1) check({tag, " flush {done,busy}"}, 32'({done, busy}), 32'd1);
            if (i == last_idx + 2) check({tag, " done {done,busy}"}, 32'({done, busy}), 32'd2);
        end
        @(negedge clk);
        din_valid = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " wr_cntr"}, 32'(wr_cntr), 32'(nw));
        got_words = {};
        for (int i = 0; i < nw; i += 2) begin
            read_pair(i, (i + 1 < nw) ? i + 1 : i, d0, d1);
            got_words.push_back(d0);
            got_words.push_back(d1);
            check({tag, " word"}, d0, exp_words[i]);
            if (i + 1 < nw) check({tag, " word"}, d1, exp_words[i + 1]);
        end
    endtask

    task automatic send_word(input logic [31:0] pat, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            sync      = 1'b0;
            din_valid = 1'b1;
            din       = pat[k % 32];
        end
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [31:0] pat;
        pat = 32'hDEADBEEF;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sync = 1'b0;
        cfg_length = '0; cfg_reverse = 1'b0; freq_div = 3'd0;
        din = 1'b0; din_valid = 1'b0; rd_en = 1'b0; rd_addr = '0;

        vecs[0] = '{63, 1'b0, 1, 0, 1'b1, 2, 32'h55555555, 32'h55555555, 2};
        vecs[1] = '{63, 1'b1, 1, 0, 1'b1, 2, 32'hAAAAAAAA, 32'hAAAAAAAA, 2};
        vecs[2] = '{39, 1'b0, 1, 1, 1'b1, 2, 32'hFFFFFFFF, 32'h000000FF, 2};
        vecs[3] = '{39, 1'b1, 1, 1, 1'b1, 2, 32'hFFFFFFFF, 32'hFF000000, 2};
        vecs[4] = '{31, 1'b0, 2, 0, 1'b1, 1, 32'h00000000, 32'h0, 1};
        vecs[5] = '{31, 1'b0, 2, 0, 1'b0, 1, 32'hFFFFFFFF, 32'h0, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wr_cntr", 32'(wr_cntr), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", rd_data, 32'd0);

        for (int v = 0; v < 6; v++) begin
            gen_pattern((vecs[v].len + 1) * vecs[v].div + 3, vecs[v].kind, vecs[v].first);
            run_capture(vecs[v].len, vecs[v].rev, vecs[v].div, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table wr_cntr", v), 32'(wr_cntr), 32'(vecs[v].wr));
            check($sformatf("vec%0d table word0", v), got_words[0], vecs[v].w0);
            if (vecs[v].nchk > 1) check($sformatf("vec%0d table word1", v), got_words[1], vecs[v].w1);
        end

        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort in DONE clears done", 32'(done), 32'd0);
        check("abort in DONE busy", 32'(busy), 32'd0);

        @(negedge clk); start = 1'b1; cfg_length = 12'd63; cfg_reverse = 1'b0; freq_div = 3'd1;
        @(negedge clk); start = 1'b0; sync = 1'b1;
        send_word(32'hFFFFFFFF, 20);
        @(negedge clk); abort = 1'b1; din_valid = 1'b1;
        @(negedge clk); abort = 1'b0; din_valid = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort wr_cntr", 32'(wr_cntr), 32'd0);
        gen_pattern(67, 0, 1'b1);
        run_capture(63, 1'b0, 1, "after abort");

        @(negedge clk); start = 1'b1; cfg_length = 12'd63; cfg_reverse = 1'b1; freq_div = 3'd3;
        @(negedge clk); start = 1'b0; sync = 1'b1;
        send_word(32'hFFFFFFFF, 10);
        gen_pattern(67, 0, 1'b1);
        run_capture(63, 1'b0, 1, "restart");

        @(negedge clk); start = 1'b1; cfg_length = 12'd100; cfg_reverse = 1'b0; freq_div = 3'd1;
        @(negedge clk); start = 1'b0; sync = 1'b1;
        send_word(32'h12345678, 40);
        @(negedge clk); rst = 1'b1; din_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst wr_cntr", 32'(wr_cntr), 32'd0);
        check("rst done", 32'(done), 32'd0);
        read_pair(0, 0, d0, d1);
        check("rst keeps RAM", d0, 32'h12345678);

`ifdef FACQ_PRN_CAPTURE_SYNC_EN
        @(negedge clk); start = 1'b1; cfg_length = 12'd31; cfg_reverse = 1'b0; freq_div = 3'd1;
        @(negedge clk); start = 1'b0; sync = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); din_valid = 1'b1; din = 1'($urandom);
        end
        check("sync arm holds", 32'(busy), 32'd1);
        @(negedge clk); sync = 1'b1; din_valid = 1'b0;
        send_word(pat, 32);
`else
        @(negedge clk); start = 1'b1; cfg_length = 12'd31; cfg_reverse = 1'b0; freq_div = 3'd1;
        @(negedge clk); start = 1'b0; sync = 1'b0; din_valid = 1'b0;
        send_word(pat, 32);
`endif
        @(negedge clk); din_valid = 1'b0;
        check("epoch flush busy", 32'({done, busy}), 32'd1);
        @(negedge clk);
        check("epoch done", 32'({done, busy}), 32'd2);
        read_pair(0, 0, d0, d1);
        check("epoch word0", d0, 32'hDEADBEEF);

        for (int r = 0; r < 6; r++) begin
            int len, div;
            bit rev;
            len = $urandom_range(0, 150);
            div = $urandom_range(0, 7);
            rev = 1'($urandom);
            gen_random(len, div);
            run_capture(len, rev, div, $sformatf("rnd%0d len%0d div%0d rev%0d", r, len, div, rev));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
